// File: rtl/toggler_pkg.sv
// Shared constants and helpers for the toggler_unit slice.
package toggler_pkg;

    localparam int TOGGLER_CNT_DEFAULT_W = 16;
    localparam int SAT_W = 32;

    // Saturating increment; callers zero-extend narrower counters into SAT_W bits.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] cnt,
        input logic [SAT_W-1:0] max
    );
        return (cnt >= max) ? cnt : cnt + SAT_W'(1);
    endfunction

endpackage

// File: rtl/toggler_unit_bit.sv
// toggler_bit: one T flip-flop with synchronous reset and parallel load.
module toggler_bit (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic t_i,
    input  logic ld_i,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            q_o <= rst_val;
        end else if (ld_i) begin
            q_o <= d_i;
        end else if (t_i) begin
            q_o <= ~q_o;
        end
    end

endmodule

// File: rtl/toggler_unit.sv
// toggler_unit: WIDTH independent T flip-flops with parallel load and change strobe.
// Define TOGGLER_CNT_EN to add the saturating toggle-cycle counter toggle_cnt_o.
module toggler_unit
    import toggler_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = TOGGLER_CNT_DEFAULT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] toggle_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic             changed_o
`ifdef TOGGLER_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt_o
`endif
);

    if (WIDTH < 1 || CNT_W < 1 || CNT_W > SAT_W) begin : g_param_check
        $error("toggler_unit: WIDTH must be >= 1 and CNT_W within 1..32");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        toggler_bit u_bit (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RESET_VAL[i]),
            .t_i     (toggle_i[i]),
            .ld_i    (load_i),
            .d_i     (load_val_i[i]),
            .q_o     (q_o[i])
        );
    end

    // Mirror of the per-bit next-state, used only to detect a change of q_o.
    logic [WIDTH-1:0] next_q;
    assign next_q = load_i ? load_val_i : (q_o ^ toggle_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_o <= 1'b0;
        end else begin
            changed_o <= (next_q != q_o);
        end
    end

`ifdef TOGGLER_CNT_EN
    localparam logic [SAT_W-1:0] CNT_MAX = {SAT_W{1'b1}} >> (SAT_W - CNT_W);

    // A load cycle never counts, even if toggle_i is non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_cnt_o <= '0;
        end else if (!load_i && (|toggle_i)) begin
            toggle_cnt_o <= CNT_W'(sat_inc(SAT_W'(toggle_cnt_o), CNT_MAX));
        end
    end
`endif

    a_inputs_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({toggle_i, load_i}));

endmodule

// File: tb/tb_toggler_unit.sv
// Self-checking bench for toggler_unit: three instances (WIDTH=1/RV=0, WIDTH=4/RV=9, WIDTH=1/RV=1).
module tb_toggler_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=1, RESET_VAL=0
    logic       rst_a, tog_a, ld_a, lv_a, q_a, ch_a;
    // Instance B: WIDTH=4, RESET_VAL=4'b1001
    logic       rst_b, ld_b, ch_b;
    logic [3:0] tog_b, lv_b, q_b;
    // Instance C: WIDTH=1, RESET_VAL=1
    logic       rst_c, tog_c, ld_c, lv_c, q_c, ch_c;
`ifdef TOGGLER_CNT_EN
    logic [2:0] cnt_a, cnt_b, cnt_c;
`endif

    toggler_unit #(.WIDTH(1), .RESET_VAL(1'b0), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst_a), .toggle_i(tog_a), .load_i(ld_a), .load_val_i(lv_a),
        .q_o(q_a), .changed_o(ch_a)
`ifdef TOGGLER_CNT_EN
        , .toggle_cnt_o(cnt_a)
`endif
    );

    toggler_unit #(.WIDTH(4), .RESET_VAL(4'b1001), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst_b), .toggle_i(tog_b), .load_i(ld_b), .load_val_i(lv_b),
        .q_o(q_b), .changed_o(ch_b)
`ifdef TOGGLER_CNT_EN
        , .toggle_cnt_o(cnt_b)
`endif
    );

    toggler_unit #(.WIDTH(1), .RESET_VAL(1'b1), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst_c), .toggle_i(tog_c), .load_i(ld_c), .load_val_i(lv_c),
        .q_o(q_c), .changed_o(ch_c)
`ifdef TOGGLER_CNT_EN
        , .toggle_cnt_o(cnt_c)
`endif
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] lval;
        logic [3:0] tog;
        logic [3:0] exp_q;
        logic       exp_ch;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h9, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'h5, 4'h5, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 4'hA, 4'hF, 4'hA, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 4'hA, 4'h0, 4'hA, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'hF, 4'h5, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 4'h8, 4'hD, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'hD, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'h6, 4'hF, 4'h9, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'h1, 4'h8, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h9, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h9, 1'b0};

        rst_a = 1'b1; tog_a = 1'b0; ld_a = 1'b0; lv_a = 1'b0;
        rst_b = 1'b1; tog_b = 4'h0; ld_b = 1'b0; lv_b = 4'h0;
        // Instance C sees load and toggle during reset: reset must win.
        rst_c = 1'b1; tog_c = 1'b1; ld_c = 1'b1; lv_c = 1'b0;

        repeat (5) step();
        check("reset_q_a", 32'(q_a), 32'h0);
        check("reset_ch_a", 32'(ch_a), 32'h0);
        check("reset_q_b", 32'(q_b), 32'h9);
        check("reset_ch_b", 32'(ch_b), 32'h0);
        check("reset_q_c", 32'(q_c), 32'h1);
        check("reset_ch_c", 32'(ch_c), 32'h0);
`ifdef TOGGLER_CNT_EN
        check("reset_cnt_a", 32'(cnt_a), 32'h0);
        check("reset_cnt_c", 32'(cnt_c), 32'h0);
`endif

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tog_c = 1'b0; ld_c = 1'b0;

        // Toggle held high: q alternates 1,0,1,0 with changed every cycle.
        tog_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_q_a", 32'(q_a), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("hold_ch_a", 32'(ch_a), 32'h1);
        end
        tog_a = 1'b0;
        step();
        check("idle_q_a", 32'(q_a), 32'h0);
        check("idle_ch_a", 32'(ch_a), 32'h0);
        tog_a = 1'b1;
        step();
        check("pulse_q_a", 32'(q_a), 32'h1);
        check("pulse_ch_a", 32'(ch_a), 32'h1);
        tog_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("after_pulse_q_a", 32'(q_a), 32'h1);
            check("after_pulse_ch_a", 32'(ch_a), 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            rst_b = vecs[i].rst;
            ld_b  = vecs[i].load;
            lv_b  = vecs[i].lval;
            tog_b = vecs[i].tog;
            step();
            check($sformatf("vec%0d_q_b", i), 32'(q_b), 32'(vecs[i].exp_q));
            check($sformatf("vec%0d_ch_b", i), 32'(ch_b), 32'(vecs[i].exp_ch));
        end

        // Instance C: RESET_VAL=1, then reset colliding with load and toggle.
        tog_c = 1'b1;
        step();
        check("c_toggle_q", 32'(q_c), 32'h0);
        check("c_toggle_ch", 32'(ch_c), 32'h1);
        rst_c = 1'b1; ld_c = 1'b1; lv_c = 1'b0; tog_c = 1'b1;
        step();
        check("c_rst_prio_q", 32'(q_c), 32'h1);
        check("c_rst_prio_ch", 32'(ch_c), 32'h0);
`ifdef TOGGLER_CNT_EN
        check("c_rst_cnt", 32'(cnt_c), 32'h0);
`endif

        // Load of the current value while toggle_i=1: no change, no count.
        rst_c = 1'b0; ld_c = 1'b1; lv_c = 1'b1; tog_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("c_load_q", 32'(q_c), 32'h1);
            check("c_load_ch", 32'(ch_c), 32'h0);
`ifdef TOGGLER_CNT_EN
            check("c_load_cnt", 32'(cnt_c), 32'h0);
`endif
        end

        ld_c = 1'b0; tog_c = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            check("c_run_q", 32'(q_c), (i % 2 == 0) ? 32'h1 : 32'h0);
`ifdef TOGGLER_CNT_EN
            check("c_run_cnt", 32'(cnt_c), (i > 7) ? 32'h7 : 32'(i));
`endif
        end

        rst_c = 1'b1; tog_c = 1'b0;
        step();
        check("c_final_rst_q", 32'(q_c), 32'h1);
        check("c_final_rst_ch", 32'(ch_c), 32'h0);
`ifdef TOGGLER_CNT_EN
        check("c_final_rst_cnt", 32'(cnt_c), 32'h0);
`endif
        rst_c = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
